// File: rtl/hazard_ctrl.sv
// Hazard/flush controller: forwarding selects, load-use/branch stalls, branch/jump flushes and syscall drain sequencing.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int DRAIN_DEPTH = 3,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs_d,
    input  logic [4:0]       rt_d,
    input  logic [4:0]       rs_e,
    input  logic [4:0]       rt_e,
    input  logic [4:0]       write_reg_e,
    input  logic [4:0]       write_reg_m,
    input  logic [4:0]       write_reg_w,
    input  logic             reg_write_e,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    input  logic             mem_to_reg_e,
    input  logic             mem_to_reg_m,
    input  logic             branch_d,
    input  logic             pc_src_d,
    input  logic             syscall_d,
    input  logic             syscall_done,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             fwd_a_d,
    output logic             fwd_b_d,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    // Out-of-range depths are clamped so the 3-bit drain counter can never wrap.
    localparam int DEPTH_C = (DRAIN_DEPTH < 1) ? 1 : ((DRAIN_DEPTH > 7) ? 7 : DRAIN_DEPTH);
    localparam logic [2:0] DRAIN_LOAD = 3'(DEPTH_C - 1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [2:0] drain_cnt_r;
    logic [2:0] drain_cnt_nxt_s;
    logic       lw_stall_s;
    logic       br_stall_s;
    logic       hz_s;

    // A producing stage matches a source only if it writes and the register is not r0.
    function automatic logic prod_hit_f(input logic we, input logic [4:0] dst, input logic [4:0] src);
        return we && (dst != 5'd0) && (dst == src);
    endfunction

    function automatic logic [1:0] fwd_sel_f(input logic [4:0] src);
        logic [1:0] sel;
        if (prod_hit_f(reg_write_m, write_reg_m, src)) begin
            sel = 2'b10;
        end else if (prod_hit_f(reg_write_w, write_reg_w, src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Forwarding selects and hazard detection, independent of the FSM state.
    always_comb begin
        fwd_a_e    = fwd_sel_f(rs_e);
        fwd_b_e    = fwd_sel_f(rt_e);
        fwd_a_d    = prod_hit_f(reg_write_m, write_reg_m, rs_d);
        fwd_b_d    = prod_hit_f(reg_write_m, write_reg_m, rt_d);
        lw_stall_s = mem_to_reg_e && (rt_e != 5'd0) && ((rt_e == rs_d) || (rt_e == rt_d));
        br_stall_s = branch_d &&
                     (prod_hit_f(reg_write_e, write_reg_e, rs_d) ||
                      prod_hit_f(reg_write_e, write_reg_e, rt_d) ||
                      prod_hit_f(mem_to_reg_m, write_reg_m, rs_d) ||
                      prod_hit_f(mem_to_reg_m, write_reg_m, rt_d));
        hz_s       = lw_stall_s || br_stall_s;
    end

    // Syscall sequencer state and drain counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_RUN;
            drain_cnt_r <= 3'd0;
        end else begin
            state_r     <= state_nxt_s;
            drain_cnt_r <= drain_cnt_nxt_s;
        end
    end

    // Next-state and stall/flush decode.
    always_comb begin
        stall_f         = 1'b0;
        stall_d         = 1'b0;
        flush_d         = 1'b0;
        flush_e         = 1'b0;
        state_nxt_s     = state_r;
        drain_cnt_nxt_s = drain_cnt_r;
        case (state_r)
            ST_RUN: begin
                if (syscall_d && !hz_s) begin
                    stall_f         = 1'b1;
                    stall_d         = 1'b1;
                    flush_e         = 1'b1;
                    flush_d         = 1'b0;
                    drain_cnt_nxt_s = DRAIN_LOAD;
                    if (DEPTH_C == 1) begin
                        state_nxt_s = ST_ISSUE;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end else begin
                    stall_f = hz_s;
                    stall_d = hz_s;
                    flush_e = hz_s;
                    flush_d = pc_src_d && !hz_s;
                end
            end
            ST_DRAIN: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
                // The counter holds the drain cycles still owed including this one.
                if (drain_cnt_r <= 3'd1) begin
                    drain_cnt_nxt_s = 3'd0;
                    state_nxt_s     = ST_ISSUE;
                end else begin
                    drain_cnt_nxt_s = drain_cnt_r - 3'd1;
                    state_nxt_s     = ST_DRAIN;
                end
            end
            ST_ISSUE: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
                if (syscall_done) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s     = ST_RUN;
                drain_cnt_nxt_s = 3'd0;
            end
        endcase
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Saturating stall and flush event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_d && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
            if ((flush_d || flush_e) && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`else
    assign stall_cnt = {CNT_W{1'b0}};
    assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus a randomized run against a behavioural model.
module tb_hazard_ctrl;

    localparam int DEPTH = 3;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [4:0]    rs_d, rt_d, rs_e, rt_e;
    logic [4:0]    write_reg_e, write_reg_m, write_reg_w;
    logic          reg_write_e, reg_write_m, reg_write_w;
    logic          mem_to_reg_e, mem_to_reg_m;
    logic          branch_d, pc_src_d, syscall_d, syscall_done;
    logic          stall_f, stall_d, flush_d, flush_e;
    logic [1:0]    fwd_a_e, fwd_b_e;
    logic          fwd_a_d, fwd_b_d;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int total;
    int bad;

    hazard_ctrl #(.DRAIN_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
        .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m),
        .branch_d(branch_d), .pc_src_d(pc_src_d), .syscall_d(syscall_d), .syscall_done(syscall_done),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs;
        rs_d = 5'd0; rt_d = 5'd0; rs_e = 5'd0; rt_e = 5'd0;
        write_reg_e = 5'd0; write_reg_m = 5'd0; write_reg_w = 5'd0;
        reg_write_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
        mem_to_reg_e = 1'b0; mem_to_reg_m = 1'b0;
        branch_d = 1'b0; pc_src_d = 1'b0; syscall_d = 1'b0; syscall_done = 1'b0;
    endtask

    task automatic pulse_reset;
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctl got=%b exp=0000", {stall_f, stall_d, flush_d, flush_e});
        end
        total++;
        if ({fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d} !== 6'b000000) begin
            bad++; $display("FAIL reset_fwd got=%b exp=000000", {fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d});
        end
        total++;
        if ({stall_cnt, flush_cnt} !== {CW{2'b00}}) begin
            bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0000) begin
            bad++; $display("FAIL idle_ctl got=%b exp=0000", {stall_f, stall_d, flush_d, flush_e});
        end
    endtask

    task automatic test_forwarding;
        @(negedge clk);
        clear_inputs();
        write_reg_m = 5'd5; reg_write_m = 1'b1; rs_e = 5'd5; rs_d = 5'd5;
        #1;
        total++;
        if (fwd_a_e !== 2'b10) begin bad++; $display("FAIL fwd_m got=%b exp=10", fwd_a_e); end
        total++;
        if (fwd_a_d !== 1'b1) begin bad++; $display("FAIL fwd_a_d got=%b exp=1", fwd_a_d); end
        write_reg_w = 5'd5; reg_write_w = 1'b1; rt_e = 5'd5;
        #1;
        total++;
        if ({fwd_a_e, fwd_b_e} !== 4'b1010) begin bad++; $display("FAIL fwd_m_prio got=%b exp=1010", {fwd_a_e, fwd_b_e}); end
        reg_write_m = 1'b0;
        #1;
        total++;
        if ({fwd_a_e, fwd_b_e, fwd_a_d} !== 5'b01010) begin
            bad++; $display("FAIL fwd_w got=%b exp=01010", {fwd_a_e, fwd_b_e, fwd_a_d});
        end
        write_reg_m = 5'd0; reg_write_m = 1'b1; write_reg_w = 5'd0; rs_e = 5'd0; rt_e = 5'd0; rs_d = 5'd0;
        #1;
        total++;
        if ({fwd_a_e, fwd_b_e, fwd_a_d} !== 5'b00000) begin
            bad++; $display("FAIL fwd_r0 got=%b exp=00000", {fwd_a_e, fwd_b_e, fwd_a_d});
        end
    endtask

    task automatic test_load_use;
        @(negedge clk);
        clear_inputs();
        mem_to_reg_e = 1'b1; rt_e = 5'd8; rs_d = 5'd8; pc_src_d = 1'b1;
        #1;
        total++;
        if ({stall_f, stall_d, flush_d, flush_e} !== 4'b1101) begin
            bad++; $display("FAIL lw_stall got=%b exp=1101", {stall_f, stall_d, flush_d, flush_e});
        end
        @(negedge clk);
        mem_to_reg_e = 1'b0;
        #1;
        total++;
        if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0010) begin
            bad++; $display("FAIL lw_release got=%b exp=0010", {stall_f, stall_d, flush_d, flush_e});
        end
    endtask

    task automatic test_branch;
        @(negedge clk);
        clear_inputs();
        branch_d = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd9; rt_d = 5'd9;
        #1;
        total++;
        if ({stall_f, stall_d, flush_e, fwd_b_d} !== 4'b1110) begin
            bad++; $display("FAIL br_stall got=%b exp=1110", {stall_f, stall_d, flush_e, fwd_b_d});
        end
        @(negedge clk);
        reg_write_e = 1'b0; write_reg_e = 5'd0; reg_write_m = 1'b1; write_reg_m = 5'd9;
        #1;
        total++;
        if ({stall_f, stall_d, flush_e, fwd_b_d} !== 4'b0001) begin
            bad++; $display("FAIL br_fwd got=%b exp=0001", {stall_f, stall_d, flush_e, fwd_b_d});
        end
    endtask

    task automatic test_syscall;
        @(negedge clk);
        clear_inputs();
        for (int c = 0; c < DEPTH; c++) begin
            @(negedge clk);
            syscall_d = 1'b1;
            #1;
            total++;
            if ({stall_f, stall_d, flush_d, flush_e} !== 4'b1101) begin
                bad++; $display("FAIL sc_drain cyc=%0d got=%b exp=1101", c, {stall_f, stall_d, flush_d, flush_e});
            end
        end
        @(negedge clk);
        #1;
        total++;
        if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0000) begin
            bad++; $display("FAIL sc_issue got=%b exp=0000", {stall_f, stall_d, flush_d, flush_e});
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            syscall_d = 1'b0; pc_src_d = 1'b1;
            #1;
            total++;
            if ({stall_f, stall_d, flush_d, flush_e} !== 4'b1101) begin
                bad++; $display("FAIL sc_wait cyc=%0d got=%b exp=1101", c, {stall_f, stall_d, flush_d, flush_e});
            end
        end
        @(negedge clk);
        syscall_done = 1'b1;
        #1;
        total++;
        if ({stall_f, stall_d, flush_d, flush_e} !== 4'b1101) begin
            bad++; $display("FAIL sc_done got=%b exp=1101", {stall_f, stall_d, flush_d, flush_e});
        end
        @(negedge clk);
        syscall_done = 1'b0;
        #1;
        total++;
        if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0010) begin
            bad++; $display("FAIL sc_run got=%b exp=0010", {stall_f, stall_d, flush_d, flush_e});
        end
    endtask

    task automatic test_reset_mid_drain;
        @(negedge clk);
        clear_inputs();
        syscall_d = 1'b1;
        @(negedge clk);
        @(negedge clk);
        syscall_d = 1'b0;
        #1;
        total++;
        if ({stall_f, stall_d, flush_d, flush_e} !== 4'b1101) begin
            bad++; $display("FAIL rstd_pre got=%b exp=1101", {stall_f, stall_d, flush_d, flush_e});
        end
        rst = 1'b1;
        #1;
        total++;
        if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0000) begin
            bad++; $display("FAIL rstd_async got=%b exp=0000", {stall_f, stall_d, flush_d, flush_e});
        end
        total++;
        if ({stall_cnt, flush_cnt} !== {CW{2'b00}}) begin
            bad++; $display("FAIL rstd_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0000) begin
            bad++; $display("FAIL rstd_after got=%b exp=0000", {stall_f, stall_d, flush_d, flush_e});
        end
    endtask

    task automatic test_random;
        int drain_left;
        bit issue_now, waiting, hz, lw, br;
        int sc, fc, esc, efc;
        logic [3:0] ectl;
        logic [5:0] efwd;
        logic [1:0] ea, eb;
        pulse_reset();
        drain_left = 0; issue_now = 1'b0; waiting = 1'b0; sc = 0; fc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
            rs_e = 5'($urandom_range(0, 3)); rt_e = 5'($urandom_range(0, 3));
            write_reg_e = 5'($urandom_range(0, 3)); write_reg_m = 5'($urandom_range(0, 3));
            write_reg_w = 5'($urandom_range(0, 3));
            reg_write_e = 1'($urandom_range(0, 1)); reg_write_m = 1'($urandom_range(0, 1));
            reg_write_w = 1'($urandom_range(0, 1));
            mem_to_reg_e = ($urandom_range(0, 3) == 0); mem_to_reg_m = ($urandom_range(0, 3) == 0);
            branch_d = ($urandom_range(0, 2) == 0); pc_src_d = 1'($urandom_range(0, 1));
            syscall_d = ($urandom_range(0, 5) == 0); syscall_done = ($urandom_range(0, 3) == 0);
            #1;
            ea = (reg_write_m && write_reg_m != 0 && write_reg_m == rs_e) ? 2'b10 :
                 (reg_write_w && write_reg_w != 0 && write_reg_w == rs_e) ? 2'b01 : 2'b00;
            eb = (reg_write_m && write_reg_m != 0 && write_reg_m == rt_e) ? 2'b10 :
                 (reg_write_w && write_reg_w != 0 && write_reg_w == rt_e) ? 2'b01 : 2'b00;
            efwd = {ea, eb, (reg_write_m && write_reg_m != 0 && write_reg_m == rs_d),
                            (reg_write_m && write_reg_m != 0 && write_reg_m == rt_d)};
            lw = mem_to_reg_e && rt_e != 0 && (rt_e == rs_d || rt_e == rt_d);
            br = branch_d && ((reg_write_e && write_reg_e != 0 && (write_reg_e == rs_d || write_reg_e == rt_d)) ||
                              (mem_to_reg_m && write_reg_m != 0 && (write_reg_m == rs_d || write_reg_m == rt_d)));
            hz = lw || br;
            if (drain_left > 0 || waiting) ectl = 4'b1101;
            else if (issue_now) ectl = 4'b0000;
            else if (syscall_d && !hz) ectl = 4'b1101;
            else ectl = {hz, hz, pc_src_d && !hz, hz};
            esc = PERF_EN ? sc : 0;
            efc = PERF_EN ? fc : 0;
            total++;
            if ({stall_f, stall_d, flush_d, flush_e} !== ectl) begin
                bad++; $display("FAIL rnd_ctl cyc=%0d got=%b exp=%b", i, {stall_f, stall_d, flush_d, flush_e}, ectl);
            end
            total++;
            if ({fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d} !== efwd) begin
                bad++; $display("FAIL rnd_fwd cyc=%0d got=%b exp=%b", i, {fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d}, efwd);
            end
            total++;
            if (stall_cnt !== CW'(esc) || flush_cnt !== CW'(efc)) begin
                bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", i, stall_cnt, flush_cnt, esc, efc);
            end
            @(posedge clk);
            if (ectl[2] && sc < CMAX) sc++;
            if ((ectl[1] || ectl[0]) && fc < CMAX) fc++;
            if (drain_left > 0) begin
                drain_left--;
                if (drain_left == 0) issue_now = 1'b1;
            end else if (issue_now) begin
                issue_now = 1'b0;
                waiting = 1'b1;
            end else if (waiting) begin
                if (syscall_done) waiting = 1'b0;
            end else if (syscall_d && !hz) begin
                drain_left = DEPTH - 1;
                if (drain_left == 0) issue_now = 1'b1;
            end
        end
    endtask

    task automatic test_counters;
        int exp10, exp_sat;
        exp10   = PERF_EN ? 10 : 0;
        exp_sat = PERF_EN ? CMAX : 0;
        pulse_reset();
        @(negedge clk);
        mem_to_reg_e = 1'b1; rt_e = 5'd8; rs_d = 5'd8;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (stall_cnt !== CW'(exp10) || flush_cnt !== CW'(exp10)) begin
            bad++; $display("FAIL cnt_10 got=%0d/%0d exp=%0d", stall_cnt, flush_cnt, exp10);
        end
        repeat (10) @(posedge clk);
        @(negedge clk);
        clear_inputs();
        #1;
        total++;
        if (stall_cnt !== CW'(exp_sat) || flush_cnt !== CW'(exp_sat)) begin
            bad++; $display("FAIL cnt_sat got=%0d/%0d exp=%0d", stall_cnt, flush_cnt, exp_sat);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_syscall();
        test_reset_mid_drain();
        test_random();
        test_counters();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
